// File: rtl/dircc_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dircc_rx_pkg
//  Description : Shared types and constants for the DIRCC node receive-slot
//                writer: FSM state encoding, header bit layout, and the
//                processing-memory address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dircc_rx_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2,
    ST_HDR  = 2'd3
  } rx_state_t;

  // Header word layout: {trunc, len[14:0]}
  localparam int TRUNC_BIT = 15;
  localparam int LEN_MSB   = 14;

  // Word-address width of the processing-memory port
  localparam int MEM_AW    = 14;

endpackage : dircc_rx_pkg
`default_nettype wire

// File: rtl/dircc_rx_slot_ring.sv
`default_nettype none
// ============================================================================
//  Module      : dircc_rx_slot_ring
//  Description : Slot bookkeeping for the receive ring. Tracks the slot being
//                filled (wr_slot), the oldest unreleased slot (rd_slot) and
//                the number of committed, unreleased slots (pending).
//                A release with nothing pending is ignored; a simultaneous
//                commit and release leaves pending unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module dircc_rx_slot_ring #(
  parameter int NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_commit,
  input  logic       i_release,
  output logic [7:0] o_wr_slot,
  output logic [7:0] o_rd_slot,
  output logic [7:0] o_pending
);

  localparam logic [7:0] c_last_slot = 8'(NUM_SLOTS - 1);

  logic [7:0] r_wr_slot;
  logic [7:0] r_rd_slot;
  logic [7:0] r_pending;
  logic       w_rel_ok;

  assign w_rel_ok = i_release && (r_pending != 8'd0);

  // Pointer wrap and pending count arithmetic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_slot <= 8'd0;
      r_rd_slot <= 8'd0;
      r_pending <= 8'd0;
    end else begin
      if (i_commit) begin
        r_wr_slot <= (r_wr_slot == c_last_slot) ? 8'd0 : r_wr_slot + 8'd1;
      end
      if (w_rel_ok) begin
        r_rd_slot <= (r_rd_slot == c_last_slot) ? 8'd0 : r_rd_slot + 8'd1;
      end
      if (i_commit && !w_rel_ok) begin
        r_pending <= r_pending + 8'd1;
      end else if (!i_commit && w_rel_ok) begin
        r_pending <= r_pending - 8'd1;
      end
    end
  end

  assign o_wr_slot = r_wr_slot;
  assign o_rd_slot = r_rd_slot;
  assign o_pending = r_pending;

endmodule : dircc_rx_slot_ring
`default_nettype wire

// File: rtl/dircc_node_rx_slot_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dircc_node_rx_slot_writer
//  Description : Receives Avalon-ST messages from the NoC and writes each one
//                into the next free slot of a ring in 16-bit processing
//                memory. Payload goes to base+1.., then a header word
//                {trunc, len} is written at base+0 and the slot is committed.
//                Over-long messages are truncated and flag overflow.
//  Options     : DIRCC_RX_IRQ_EN - when defined, irq is a registered
//                (pending != 0); otherwise irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module dircc_node_rx_slot_writer
  import dircc_rx_pkg::*;
#(
  parameter int BASE_WORD  = 0,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [15:0]       snk_data,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  output logic [15:0]       mem_writedata,
  input  logic              rel_pulse,
  input  logic              ovf_clr,
  output logic [7:0]        pending,
  output logic [7:0]        wr_slot,
  output logic [7:0]        rd_slot,
  output logic              overflow,
  output logic              irq
);

  if (BASE_WORD + NUM_SLOTS * SLOT_WORDS > 16384) begin : g_range_check
    $error("dircc_node_rx_slot_writer: receive ring exceeds processing memory");
  end

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              w_last_data;
  logic              w_commit;
  logic              w_trunc_evt;
  logic [14:0]       r_len;
  logic              r_trunc;
  logic              r_overflow;
  logic              r_mem_wr;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [15:0]       r_mem_data;
  logic              w_wr_en;
  logic [MEM_AW-1:0] w_wr_addr;
  logic [15:0]       w_wr_data;
  logic [MEM_AW-1:0] w_base;
  logic [15:0]       w_hdr;
  logic [7:0]        w_wr_slot;
  logic [7:0]        w_rd_slot;
  logic [7:0]        w_pending;

  assign w_base      = MEM_AW'(BASE_WORD + int'(w_wr_slot) * SLOT_WORDS);
  assign snk_ready   = w_ready & reset_n;
  assign w_accept    = snk_valid & snk_ready;
  assign w_last_data = (r_len == 15'(SLOT_WORDS - 2));
  assign w_commit    = (r_state == ST_HDR);
  assign w_trunc_evt = (r_state == ST_DATA) && w_accept && !snk_eop && w_last_data;

  // Header word assembled from the recorded length and truncation flag
  always_comb begin
    w_hdr              = '0;
    w_hdr[TRUNC_BIT]   = r_trunc;
    w_hdr[LEN_MSB:0]   = r_len;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && snk_sop) w_state_nxt = snk_eop ? ST_HDR : ST_DATA;
      ST_DATA: begin
        if (w_accept) begin
          if (snk_eop)          w_state_nxt = ST_HDR;
          else if (w_last_data) w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: if (w_accept && snk_eop) w_state_nxt = ST_HDR;
      ST_HDR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: sink back-pressure (IDLE waits for a free slot, HDR stalls)
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = (int'(w_pending) < NUM_SLOTS);
      ST_DATA: w_ready = 1'b1;
      ST_DROP: w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  // Write request for this cycle; it is registered onto the memory port
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_base;
    w_wr_data = snk_data;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && snk_sop) begin
          w_wr_en   = 1'b1;
          w_wr_addr = w_base + MEM_AW'(1);
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_wr_en   = 1'b1;
          w_wr_addr = w_base + MEM_AW'(1) + r_len[MEM_AW-1:0];
        end
      end
      ST_HDR: begin
        w_wr_en   = 1'b1;
        w_wr_data = w_hdr;
      end
      default: ;
    endcase
  end

  // Registered memory strobes, length/truncation tracking and overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_len      <= '0;
      r_trunc    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_mem_wr <= w_wr_en;
      if (w_wr_en) begin
        r_mem_addr <= w_wr_addr;
        r_mem_data <= w_wr_data;
      end
      if ((r_state == ST_IDLE) && w_accept && snk_sop) begin
        r_len   <= 15'd1;
        r_trunc <= 1'b0;
      end else if ((r_state == ST_DATA) && w_accept) begin
        r_len <= r_len + 15'd1;
        if (w_trunc_evt) r_trunc <= 1'b1;
      end
      if (w_trunc_evt)  r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  dircc_rx_slot_ring #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ring (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_commit  (w_commit),
    .i_release (rel_pulse),
    .o_wr_slot (w_wr_slot),
    .o_rd_slot (w_rd_slot),
    .o_pending (w_pending)
  );

`ifdef DIRCC_RX_IRQ_EN
  logic r_irq;

  // Interrupt follows pending != 0 with one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= (w_pending != 8'd0);
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign mem_address    = r_mem_addr;
  assign mem_chipselect = r_mem_wr;
  assign mem_write      = r_mem_wr;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;
  assign mem_writedata  = r_mem_data;
  assign pending        = w_pending;
  assign wr_slot        = w_wr_slot;
  assign rd_slot        = w_rd_slot;
  assign overflow       = r_overflow;

endmodule : dircc_node_rx_slot_writer
`default_nettype wire

// File: tb/tb_dircc_node_rx_slot_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dircc_node_rx_slot_writer
//  Description : Self-checking bench for the receive-slot writer with a
//                message-level reference model and directed + random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_node_rx_slot_writer;

  localparam int BW = 'h1000;
  localparam int NS = 4;
  localparam int SW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic [15:0] snk_data = 16'h0;
  logic [13:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [1:0]  mem_byteenable;
  logic        mem_clken;
  logic [15:0] mem_writedata;
  logic        rel_pulse = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [7:0]  pending;
  logic [7:0]  wr_slot;
  logic [7:0]  rd_slot;
  logic        overflow;
  logic        irq;

  dircc_node_rx_slot_writer #(
    .BASE_WORD  (BW),
    .NUM_SLOTS  (NS),
    .SLOT_WORDS (SW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_data       (snk_data),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_writedata  (mem_writedata),
    .rel_pulse      (rel_pulse),
    .ovf_clr        (ovf_clr),
    .pending        (pending),
    .wr_slot        (wr_slot),
    .rd_slot        (rd_slot),
    .overflow       (overflow),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int log_a[$];
  int log_d[$];
  int log_c[$];

  logic rand_en = 1'b0;
  logic req_rel = 1'b0;
  logic req_clr = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (message/slot level) ----------------
  int   m_pending = 0, m_wr = 0, m_rd = 0, m_cnt = 0;
  logic m_in_pkt = 0, m_drop = 0, m_hdr = 0, m_trunc = 0, m_ovf = 0, m_irq = 0;
  logic m_exp_wr = 0;
  int   m_exp_addr = 0, m_exp_data = 0;

  function automatic int slot_base(input int s);
    return BW + s * SW;
  endfunction

  function automatic logic model_ready();
    return !m_hdr && (m_in_pkt || m_drop || (m_pending < NS));
  endfunction

  always @(posedge clk) begin
    logic acc, commit, rel_ok, ovf_set, irq_next;
    if (!reset_n) begin
      m_pending = 0; m_wr = 0; m_rd = 0; m_cnt = 0;
      m_in_pkt = 0; m_drop = 0; m_hdr = 0; m_trunc = 0; m_ovf = 0; m_irq = 0;
      m_exp_wr = 0;
    end else begin
      acc      = snk_valid && model_ready();
      commit   = m_hdr;
      irq_next = (m_pending != 0);
      ovf_set  = 0;
      m_exp_wr = 0;
      if (commit) begin
        m_exp_wr   = 1;
        m_exp_addr = slot_base(m_wr);
        m_exp_data = (int'(m_trunc) << 15) | m_cnt;
        m_hdr      = 0;
      end else if (acc) begin
        if (m_in_pkt) begin
          m_exp_wr   = 1;
          m_exp_addr = slot_base(m_wr) + 1 + m_cnt;
          m_exp_data = int'(snk_data);
          m_cnt++;
          if (snk_eop) begin
            m_in_pkt = 0; m_hdr = 1;
          end else if (m_cnt == SW - 1) begin
            m_in_pkt = 0; m_drop = 1; m_trunc = 1; ovf_set = 1;
          end
        end else if (m_drop) begin
          if (snk_eop) begin
            m_drop = 0; m_hdr = 1;
          end
        end else if (snk_sop) begin
          m_exp_wr   = 1;
          m_exp_addr = slot_base(m_wr) + 1;
          m_exp_data = int'(snk_data);
          m_cnt      = 1;
          m_trunc    = 0;
          if (snk_eop) m_hdr = 1;
          else         m_in_pkt = 1;
        end
      end
      rel_ok = rel_pulse && (m_pending > 0);
      if (commit) m_wr = (m_wr + 1) % NS;
      if (rel_ok) m_rd = (m_rd + 1) % NS;
      m_pending = m_pending + int'(commit) - int'(rel_ok);
      if (ovf_set)      m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
`ifdef DIRCC_RX_IRQ_EN
      m_irq = irq_next;
`else
      m_irq = 0;
`endif
    end
  end

  // ---------------- compare process + write log ----------------
  always @(negedge clk) begin
    cyc++;
    if (mem_write) begin
      log_a.push_back(int'(mem_address));
      log_d.push_back(int'(mem_writedata));
      log_c.push_back(cyc);
    end
    chk("byteenable", int'(mem_byteenable), 3);
    chk("clken", int'(mem_clken), 1);
    chk("cs_eq_write", int'(mem_chipselect), int'(mem_write));
    if (!reset_n) begin
      chk("rst_ready", int'(snk_ready), 0);
      chk("rst_write", int'(mem_write), 0);
      chk("rst_addr", int'(mem_address), 0);
      chk("rst_wdata", int'(mem_writedata), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_wr_slot", int'(wr_slot), 0);
      chk("rst_rd_slot", int'(rd_slot), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_irq", int'(irq), 0);
    end else begin
      chk("ready", int'(snk_ready), int'(model_ready()));
      chk("mem_write", int'(mem_write), int'(m_exp_wr));
      if (m_exp_wr) begin
        chk("mem_address", int'(mem_address), m_exp_addr);
        chk("mem_writedata", int'(mem_writedata), m_exp_data);
      end
      chk("pending", int'(pending), m_pending);
      chk("wr_slot", int'(wr_slot), m_wr);
      chk("rd_slot", int'(rd_slot), m_rd);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("irq", int'(irq), int'(m_irq));
    end
  end

  // ---------------- side-band driver (release / overflow clear) ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rel_pulse = rand_en ? ($urandom % 6 == 0) : req_rel;
      ovf_clr   = rand_en ? ($urandom % 9 == 0) : req_clr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic s, input logic e);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    snk_data = d; snk_sop = s; snk_eop = e; snk_valid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      got = snk_ready;
      @(posedge clk);
      #1;
      n++;
    end
    snk_valid = 1'b0;
    chk("send_timeout", int'(got), 1);
  endtask

  task automatic pulse_rel();
    req_rel = 1'b1;
    idle(1);
    req_rel = 1'b0;
  endtask

  task automatic pulse_clr();
    req_clr = 1'b1;
    idle(1);
    req_clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    idle(n);
    reset_n = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int idx, input int a, input int d);
    if (idx < log_a.size()) begin
      chk({nm, "_addr"}, log_a[idx], a);
      chk({nm, "_data"}, log_d[idx], d);
    end else begin
      chk({nm, "_missing"}, log_a.size(), idx + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b;
    int len;
    logic nosop;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // Three-word packet into slot 0
    b = log_a.size();
    send_word(16'hA001, 1'b1, 1'b0);
    send_word(16'hA002, 1'b0, 1'b0);
    send_word(16'hA003, 1'b0, 1'b1);
    idle(4);
    chk("p0_nwr", log_a.size() - b, 4);
    chk_log("p0_w1", b,     'h1001, 'hA001);
    chk_log("p0_w2", b + 1, 'h1002, 'hA002);
    chk_log("p0_w3", b + 2, 'h1003, 'hA003);
    chk_log("p0_hdr", b + 3, 'h1000, 'h0003);
    if (log_c.size() >= b + 4) chk("p0_consec", log_c[b+3] - log_c[b], 3);
    chk("p0_pending", int'(pending), 1);
    chk("p0_wr_slot", int'(wr_slot), 1);
`ifdef DIRCC_RX_IRQ_EN
    chk("p0_irq", int'(irq), 1);
`else
    chk("p0_irq", int'(irq), 0);
`endif
    pulse_rel();
    idle(2);

    // 20-word packet into slot 1: truncated at 15 payload words
    b = log_a.size();
    for (int i = 0; i < 20; i++) send_word(16'hB000 + 16'(i), (i == 0), (i == 19));
    idle(4);
    chk("trunc_nwr", log_a.size() - b, 16);
    chk_log("trunc_first", b,      'h1011, 'hB000);
    chk_log("trunc_last",  b + 14, 'h101F, 'hB00E);
    chk_log("trunc_hdr",   b + 15, 'h1010, 'h800F);
    chk("trunc_ovf", int'(overflow), 1);
    pulse_clr();
    idle(2);
    chk("ovf_cleared", int'(overflow), 0);
    pulse_rel();
    idle(2);

    // Reset in the middle of a packet: no commit, no header
    send_word(16'hE001, 1'b1, 1'b0);
    send_word(16'hE002, 1'b0, 1'b0);
    send_word(16'hE003, 1'b0, 1'b0);
    b = log_a.size();
    do_reset(2);
    idle(3);
    chk("rst_nohdr", log_a.size() - b, 0);
    chk("rst_pend0", int'(pending), 0);
    chk("rst_wr0", int'(wr_slot), 0);
    b = log_a.size();
    send_word(16'hC001, 1'b1, 1'b0);
    send_word(16'hC002, 1'b0, 1'b1);
    idle(3);
    chk_log("after_rst_w1", b, 'h1001, 'hC001);
    chk_log("after_rst_hdr", b + 2, 'h1000, 'h0002);
    do_reset(2);
    idle(1);

    // Fill all four slots, fifth stalls until a release
    for (int p = 0; p < 4; p++) send_word(16'hD000 + 16'(p), 1'b1, 1'b1);
    idle(3);
    chk("full_pending", int'(pending), 4);
    b = log_a.size();
    snk_data = 16'h5555; snk_sop = 1'b1; snk_eop = 1'b1; snk_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", int'(snk_ready), 0);
      @(posedge clk);
      #1;
    end
    pulse_rel();
    send_word(16'h5555, 1'b1, 1'b1);
    idle(3);
    chk_log("fifth_w1", b, 'h1001, 'h5555);
    chk_log("fifth_hdr", b + 1, 'h1000, 'h0001);
    chk("fifth_pending", int'(pending), 4);

    // Release coincident with the header cycle
    pulse_rel();
    pulse_rel();
    idle(2);
    chk("pre_hdr_pending", int'(pending), 2);
    b = log_a.size();
    send_word(16'hBEEF, 1'b1, 1'b1);
    pulse_rel();
    idle(3);
    chk("hdrrel_pending", int'(pending), 2);
    chk("hdrrel_rd", int'(rd_slot), 0);
    chk("hdrrel_wr", int'(wr_slot), 2);
    chk_log("beef_w1", b, 'h1011, 'hBEEF);
    chk_log("beef_hdr", b + 1, 'h1010, 'h0001);
    if (log_c.size() >= b + 2) chk("beef_consec", log_c[b+1] - log_c[b], 1);

    // Randomized traffic
    rand_en = 1'b1;
    for (int p = 0; p < 80; p++) begin
      len   = $urandom_range(1, 20);
      nosop = ($urandom % 10 == 0);
      for (int i = 0; i < len; i++) begin
        idle($urandom % 3);
        if (i == 2 && ($urandom % 25 == 0)) begin
          do_reset(2);
          break;
        end
        send_word(16'($urandom), (i == 0 && !nosop) || ($urandom % 12 == 0), (i == len - 1));
      end
    end
    rand_en = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dircc_node_rx_slot_writer
`default_nettype wire
